// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and the receiver.
//   parity_t        : parity mode encoding (NONE, EVEN, ODD)
//   uart_tx_state_t : transmitter frame states
//   baud_div()      : clock cycles per bit, integer truncation
package uart_pkg;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      EVEN = 2'd1,
      ODD  = 2'd2
   } parity_t;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_tx_state_t;

   localparam int MIN_BAUD_DIV = 2;

   function automatic int baud_div(input int clk_freq, input int speed);
      return clk_freq / speed;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period generator. Counts 0..DIV-1 while enabled and pulses tick on the
// last count of each period. clr restarts the period from 0, which lets a
// receiver re-phase the counter on a detected start edge.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   clr  : hold the counter at 0 (takes priority over en)
//   en   : advance the counter
//   tick : high during the final cycle of each bit period
module uart_baud_gen #(
   parameter int DIV = 434
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int               CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] cnt;

   // NOTE: sequential state is written with <= only, so every flop samples
   // the pre-edge value of every other flop.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (en) begin
         if (cnt == LAST) cnt <= '0;
         else             cnt <= cnt + CNT_W'(1);
      end
   end

   assign tick = en && !clr && (cnt == LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter with valid/ready input. Sends start bit, BUS_WIDTH data
// bits LSB first, optional parity bit and STOP_BITS stop bits.
//   clk     : system clock
//   rst     : synchronous active-high reset
//   data_i  : word to send, captured on acceptance
//   valid_i : producer has a word
//   ready_o : can accept; transfer on an edge where valid_i && ready_o
//   tx_o    : registered serial line, idle high
//   busy_o  : frame in progress
module uart_tx_frame
   import uart_pkg::*;
#(
   parameter int CLK_FREQ    = 50000000,
   parameter int UART_SPEED  = 115200,
   parameter int BUS_WIDTH   = 8,
   parameter int PARITY_MODE = 0,
   parameter int STOP_BITS   = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [BUS_WIDTH-1:0] data_i,
   input  logic                 valid_i,
   output logic                 ready_o,
   output logic                 tx_o,
   output logic                 busy_o
);

   localparam int               DIV       = baud_div(CLK_FREQ, UART_SPEED);
   localparam parity_t          PAR       = parity_t'(2'(PARITY_MODE));
   localparam int               BIT_W     = 4;
   localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(BUS_WIDTH - 1);
   localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

   if (DIV < MIN_BAUD_DIV) begin : g_bad_div
      $error("uart_tx_frame: CLK_FREQ/UART_SPEED must be at least 2");
   end
   if (BUS_WIDTH < 5 || BUS_WIDTH > 9) begin : g_bad_width
      $error("uart_tx_frame: BUS_WIDTH must be 5..9");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("uart_tx_frame: STOP_BITS must be 1 or 2");
   end
   if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
      $error("uart_tx_frame: PARITY_MODE must be 0, 1 or 2");
   end

   uart_tx_state_t       state;
   logic [BUS_WIDTH-1:0] shreg;
   logic [BIT_W-1:0]     bit_cnt;
   logic                 stop_cnt;
   logic                 par_bit;
   logic                 tx_q;
   logic                 ready_q;
   logic                 tick;
   logic                 baud_clr;
   logic                 baud_en;
   logic                 accept;

   // The counter sits at 0 in IDLE, so the first bit of a frame always gets
   // a full period no matter when the word arrives.
   assign baud_clr = (state == IDLE);
   assign baud_en  = (state != IDLE);

   uart_baud_gen #(
      .DIV (DIV)
   ) u_baud (
      .clk  (clk),
      .rst  (rst),
      .clr  (baud_clr),
      .en   (baud_en),
      .tick (tick)
   );

   assign accept = valid_i && ready_o;

   // Each branch loads tx_q with the level of the state being entered, so the
   // line moves only on bit boundaries.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the shift register is an ordinary datapath register, so it
         // is cleared with the rest of the state rather than left undefined.
         state    <= IDLE;
         shreg    <= '0;
         bit_cnt  <= '0;
         stop_cnt <= 1'b0;
         par_bit  <= 1'b0;
         tx_q     <= 1'b1;
         ready_q  <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  shreg    <= data_i;
                  par_bit  <= (^data_i) ^ (PAR == ODD);
                  bit_cnt  <= '0;
                  stop_cnt <= 1'b0;
                  tx_q     <= 1'b0;
                  ready_q  <= 1'b0;
                  state    <= START;
               end
            end
            START: begin
               if (tick) begin
                  tx_q  <= shreg[0];
                  state <= DATA;
               end
            end
            DATA: begin
               if (tick) begin
                  shreg <= shreg >> 1;
                  if (bit_cnt == LAST_BIT) begin
                     if (PAR != NONE) begin
                        tx_q  <= par_bit;
                        state <= PARITY;
                     end else begin
                        tx_q  <= 1'b1;
                        state <= STOP;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + BIT_W'(1);
                     tx_q    <= shreg[1];
                  end
               end
            end
            PARITY: begin
               if (tick) begin
                  tx_q  <= 1'b1;
                  state <= STOP;
               end
            end
            STOP: begin
               if (tick) begin
                  if (stop_cnt == LAST_STOP) begin
                     ready_q <= 1'b1;
                     state   <= IDLE;
                  end else begin
                     stop_cnt <= stop_cnt + 1'b1;
                  end
               end
            end
            default: begin
               tx_q    <= 1'b1;
               ready_q <= 1'b1;
               state   <= IDLE;
            end
         endcase
      end
   end

   // ready_q is already high after the reset edge; gating with rst keeps the
   // handshake closed while reset is held and opens it the cycle rst drops.
   assign ready_o = ready_q && !rst;
   assign busy_o  = !ready_q && !rst;
   assign tx_o    = tx_q;

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter with valid/ready input handshake, configurable data width, parity mode and stop-bit count. It sits between a byte-stream producer (CPU peripheral register or TX FIFO) and the UART `tx` pin. The baud counter restarts on every accepted word, so each bit lasts exactly one divider period regardless of when the request arrives. Data is captured on acceptance, so the producer may change `data_i` immediately afterwards.

## Interface
- `CLK_FREQ`, 50000000: system clock frequency in Hz.
- `UART_SPEED`, 115200: baud rate.
- `BUS_WIDTH`, 8: data bits per frame, sent LSB first. Legal range 5..9.
- `PARITY_MODE`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: 1 or 2.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `data_i`  in  BUS_WIDTH  word to transmit; sampled only on acceptance.
- `valid_i`  in  1  producer has a word.
- `ready_o`  out  1  block can accept; a transfer occurs on a `clk` edge where `valid_i && ready_o`.
- `tx_o`  out  1  serial line, registered, idle high.
- `busy_o`  out  1  frame in progress, equal to `!ready_o` outside reset.

## Operation
- Divider: DIV = CLK_FREQ / UART_SPEED, integer truncation. Elaboration fails if DIV < 2, if BUS_WIDTH is outside 5..9, if STOP_BITS is not 1 or 2, or if PARITY_MODE > 2.
- States:
  - IDLE: `tx_o` = 1, `ready_o` = 1. On accept, latch `data_i` into the shift register and compute parity from the latched value, then go to START. The baud counter clears to 0.
  - START: `tx_o` = 0 for DIV cycles, then go to DATA.
  - DATA: `tx_o` = `shreg[0]` for DIV cycles per bit, shifting right at each bit end. The bit counter runs 0..BUS_WIDTH-1. After the last bit, go to PARITY if PARITY_MODE != 0, otherwise go to STOP.
  - PARITY: `tx_o` = XOR of the data bits for even parity, or its inverse for odd parity, for DIV cycles. Then go to STOP.
  - STOP: `tx_o` = 1 for STOP_BITS × DIV cycles, then go to IDLE.
- Baud counter: width $clog2(DIV). It counts 0..DIV-1, and the tick asserts when the count equals DIV-1. It is held at 0 in IDLE.
- Outputs are registered from the next state, so `tx_o` changes exactly on bit boundaries with no glitches.
- `valid_i` is ignored while `ready_o` = 0. No word is dropped or duplicated.
- Reset (any state, mid-frame included):
  - Next cycle: state = IDLE, `tx_o` = 1, all counters 0, shift register 0.
  - `ready_o` = 0 and `busy_o` = 0 while `rst` is high.
  - `ready_o` = 1 from the first cycle after `rst` deasserts.
  - The aborted frame is not resumed.

## Timing
- Accept at edge N: `tx_o` falls at edge N+1. `ready_o` is low from N+1.
- Frame length F = (1 + BUS_WIDTH + (PARITY_MODE != 0) + STOP_BITS) × DIV cycles, measured from the `tx_o` falling edge.
- `ready_o` returns high at edge N+1+F. With `valid_i` held high, the next accept occurs at that edge, giving exactly one extra idle-high cycle between frames.
- Throughput: one word per F+1 cycles.
- A `valid_i` deassertion mid-frame has no effect on the frame in flight.

## Structure
- `uart_pkg`, shared with the receiver, holds:
  - the `parity_t` enum: NONE, EVEN, ODD;
  - the `uart_tx_state_t` enum: IDLE, START, DATA, PARITY, STOP;
  - the function `baud_div(clk_freq, speed)`.
- Sub-module `uart_baud_gen`:
  - inputs: `clk`, `rst`, `clr`, `en`;
  - output: `tick`;
  - parameter: `DIV`.
  - It is reusable by the receiver with a half-period start offset.
- The top contains the FSM, shift register, bit/stop counters, parity register and the output register.

## Test plan
All scenarios use CLK_FREQ = 1000000 and UART_SPEED = 100000, giving DIV = 10.

- 8N1, send 0x55 → `tx_o` shows 0,1,0,1,0,1,0,1,0,1 with each level held for 10 cycles, then 1. `ready_o` is low for exactly 100 cycles.
- 8E1, send 0x07 → parity bit 1. 8O1, send 0x07 → parity bit 0. F = 110 cycles in both cases.
- 7N2, send 0x7F → start bit, seven 1s, then 20 cycles high, then `ready_o` rises. F = 100 cycles.
- `valid_i` held high with 0xA3 then 0x3C, and `data_i` changed on the cycle after each accept → both frames are correct and the gap between the first stop bit's end and the second start bit is 1 cycle.
- Assert `rst` for 1 cycle during data bit 3 → `tx_o` = 1 next cycle and `ready_o` = 1 after. A new 0x81 sent afterwards produces a complete, correct frame.
- `valid_i` pulsed while busy → ignored. No extra frame appears on `tx_o`.
